// File: rtl/arbb_pkg.sv
// Shared types and field positions for the 2x2 flit port allocator.
// Flit layout: [9]=golden, [8:6]=direction, [5:0]=payload.
package arbb_pkg;

  localparam int FLIT_W   = 10;
  localparam int GOLD_BIT = 9;
  localparam int DIR_HI   = 8;
  localparam int DIR_LO   = 6;

  localparam logic [2:0] DIR_OUT1 = 3'b010;

  typedef logic [FLIT_W-1:0] flit_t;

  // 0 = wants out1, 1 = wants out2
  function automatic logic want_of(flit_t f);
    return f[DIR_HI:DIR_LO] != DIR_OUT1;
  endfunction

endpackage

// File: rtl/arbb_if.sv
// Flit bus between input latches, the allocator and the output links.
// The allocator attaches through the slave modport.
interface arbb_if;
  import arbb_pkg::*;

  flit_t inp1;
  logic  inp1_vld;
  flit_t inp2;
  logic  inp2_vld;
  flit_t out1;
  logic  out1_vld;
  flit_t out2;
  logic  out2_vld;

  modport master (
    output inp1, inp1_vld, inp2, inp2_vld,
    input  out1, out1_vld, out2, out2_vld
  );

  modport slave (
    input  inp1, inp1_vld, inp2, inp2_vld,
    output out1, out1_vld, out2, out2_vld
  );

endinterface

// File: rtl/arbb_pick.sv
// Combinational conflict detect and winner select (0 = inp1, 1 = inp2).
// Priority: lone starved input, then rr, then lone golden, then rr.
module arbb_pick (
  input  logic v1_i,
  input  logic v2_i,
  input  logic w1_i,
  input  logic w2_i,
  input  logic g1_i,
  input  logic g2_i,
  input  logic sat1_i,
  input  logic sat2_i,
  input  logic rr_i,
  output logic conflict_o,
  output logic win_o
);

  assign conflict_o = v1_i & v2_i & (w1_i == w2_i);

  always_comb begin
    win_o = rr_i;
    priority case (1'b1)
      sat1_i ^ sat2_i: win_o = sat2_i;
      sat1_i & sat2_i: win_o = rr_i;
      g1_i ^ g2_i:     win_o = g2_i;
      default:         win_o = rr_i;
    endcase
  end

endmodule

// File: rtl/arbb_sched.sv
// Registered 2x2 deflection port allocator, one-cycle latency.
// Optional saturating deflection counter enabled by ARBB_DEFL_CNT_EN.
module arbb_sched
  import arbb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  arbb_if.slave            bus
`ifdef ARBB_DEFL_CNT_EN
  ,
  output logic [CNT_W-1:0] defl_cnt
`endif
);

  localparam int SW = 4;
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  flit_t          o1_q, o1_d;
  flit_t          o2_q, o2_d;
  logic           v1_q, v1_d;
  logic           v2_q, v2_d;
  logic           rr_q, rr_d;
  logic [SW-1:0]  s1_q, s1_d;
  logic [SW-1:0]  s2_q, s2_d;

  logic  w1, w2;
  logic  sat1, sat2;
  logic  conflict, win;
  flit_t wf, lf;

  assign w1   = want_of(bus.inp1);
  assign w2   = want_of(bus.inp2);
  assign sat1 = (s1_q == SMAX);
  assign sat2 = (s2_q == SMAX);

  arbb_pick u_pick (
    .v1_i      (bus.inp1_vld),
    .v2_i      (bus.inp2_vld),
    .w1_i      (w1),
    .w2_i      (w2),
    .g1_i      (bus.inp1[GOLD_BIT]),
    .g2_i      (bus.inp2[GOLD_BIT]),
    .sat1_i    (sat1),
    .sat2_i    (sat2),
    .rr_i      (rr_q),
    .conflict_o(conflict),
    .win_o     (win)
  );

  assign wf = win ? bus.inp2 : bus.inp1;
  assign lf = win ? bus.inp1 : bus.inp2;

  always_comb begin
    o1_d = o1_q;
    o2_d = o2_q;
    v1_d = 1'b0;
    v2_d = 1'b0;
    rr_d = rr_q;
    s1_d = s1_q;
    s2_d = s2_q;
    if (conflict) begin
      v1_d = 1'b1;
      v2_d = 1'b1;
      // both want the same port, so w1 names it
      if (w1) begin
        o1_d = lf;
        o2_d = wf;
      end else begin
        o1_d = wf;
        o2_d = lf;
      end
      rr_d = ~win;
      if (win) begin
        s2_d = '0;
        s1_d = sat1 ? s1_q : s1_q + 1'b1;
      end else begin
        s1_d = '0;
        s2_d = sat2 ? s2_q : s2_q + 1'b1;
      end
    end else begin
      if (bus.inp1_vld) begin
        if (w1) begin
          o2_d = bus.inp1;
          v2_d = 1'b1;
        end else begin
          o1_d = bus.inp1;
          v1_d = 1'b1;
        end
      end
      if (bus.inp2_vld) begin
        if (w2) begin
          o2_d = bus.inp2;
          v2_d = 1'b1;
        end else begin
          o1_d = bus.inp2;
          v1_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o1_q <= '0;
      o2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      rr_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      o1_q <= o1_d;
      o2_q <= o2_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      rr_q <= rr_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign bus.out1     = o1_q;
  assign bus.out2     = o2_q;
  assign bus.out1_vld = v1_q;
  assign bus.out2_vld = v2_q;

`ifdef ARBB_DEFL_CNT_EN
  logic [CNT_W-1:0] defl_q, defl_d;

  always_comb begin
    defl_d = defl_q;
    if (conflict && (defl_q != '1))
      defl_d = defl_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) defl_q <= '0;
    else     defl_q <= defl_d;
  end

  assign defl_cnt = defl_q;
`endif

endmodule

// File: tb/tb_arbb_sched.sv
// Directed bench for arbb_sched with hand-computed expectations.
// Build with +define+ARBB_DEFL_CNT_EN to also check the deflection counter.
module tb_arbb_sched;
  import arbb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  arbb_if bus ();

`ifdef ARBB_DEFL_CNT_EN
  logic [15:0] defl_cnt;
`endif

  arbb_sched #(.STARVE_MAX(4), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef ARBB_DEFL_CNT_EN
    ,
    .defl_cnt(defl_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive inputs, then sample 1 time unit after the capturing edge
  task automatic cyc(input logic [9:0] a, input logic av,
                     input logic [9:0] b, input logic bv);
    bus.inp1     = a;
    bus.inp1_vld = av;
    bus.inp2     = b;
    bus.inp2_vld = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic expo(input string tag,
                      input logic e1v, input logic [9:0] e1,
                      input logic e2v, input logic [9:0] e2);
    chk({tag, ".v1"}, 16'(bus.out1_vld), 16'(e1v));
    chk({tag, ".v2"}, 16'(bus.out2_vld), 16'(e2v));
    if (e1v) chk({tag, ".o1"}, 16'(bus.out1), 16'(e1));
    if (e2v) chk({tag, ".o2"}, 16'(bus.out2), 16'(e2));
  endtask

  task automatic expd(input string tag, input logic [15:0] e);
`ifdef ARBB_DEFL_CNT_EN
    chk(tag, defl_cnt, e);
`else
    if (e == 16'hFFFF) $display("unused %s", tag);
`endif
  endtask

  initial begin
    // reset held 2 cycles with traffic present
    rst = 1'b1;
    cyc(10'h080, 1, 10'h0C0, 1);
    cyc(10'h080, 1, 10'h0C0, 1);
    chk("rst.o1", 16'(bus.out1), 16'h0);
    chk("rst.o2", 16'(bus.out2), 16'h0);
    expo("rst", 0, 0, 0, 0);
    expd("rst.defl", 16'd0);
    rst = 1'b0;

    // first conflict after reset: rr favours inp1
    cyc(10'h080, 1, 10'h081, 1);
    expo("rr0", 1, 10'h080, 1, 10'h081);
    // different wants, no arbitration
    cyc(10'h080, 1, 10'h0C0, 1);
    expo("nocf", 1, 10'h080, 1, 10'h0C0);
    // rr must still point at inp2
    cyc(10'h085, 1, 10'h086, 1);
    expo("rr1", 1, 10'h086, 1, 10'h085);
    // golden inp2 beats non-golden inp1 though rr favours inp1
    cyc(10'h080, 1, 10'h280, 1);
    expo("gold", 1, 10'h280, 1, 10'h080);
    expd("gold.defl", 16'd3);

    // reset then four plain conflicts alternate
    rst = 1'b1;
    cyc(10'h0A1, 1, 10'h0B2, 1);
    expo("rst2", 0, 0, 0, 0);
    expd("rst2.defl", 16'd0);
    rst = 1'b0;
    cyc(10'h0A1, 1, 10'h0B2, 1);
    expo("alt1", 1, 10'h0A1, 1, 10'h0B2);
    cyc(10'h0A1, 1, 10'h0B2, 1);
    expo("alt2", 1, 10'h0B2, 1, 10'h0A1);
    cyc(10'h0A1, 1, 10'h0B2, 1);
    expo("alt3", 1, 10'h0A1, 1, 10'h0B2);
    cyc(10'h0A1, 1, 10'h0B2, 1);
    expo("alt4", 1, 10'h0B2, 1, 10'h0A1);
    expd("alt.defl", 16'd4);

    // starvation: golden inp2 wins 4x, then starved inp1 is forced
    rst = 1'b1;
    cyc(10'h081, 0, 10'h282, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(10'h081, 1, 10'h282, 1);
      expo($sformatf("stv%0d", i), 1, 10'h282, 1, 10'h081);
    end
    cyc(10'h081, 1, 10'h282, 1);
    expo("stv.force", 1, 10'h081, 1, 10'h282);
    // starve1 cleared, golden wins again
    cyc(10'h081, 1, 10'h282, 1);
    expo("stv.clear", 1, 10'h282, 1, 10'h081);
    expd("stv.defl", 16'd6);
    // conflict on out2, rr back on inp1
    cyc(10'h1C1, 1, 10'h1C2, 1);
    expo("cf.out2", 1, 10'h1C2, 1, 10'h1C1);
    expd("cf.defl", 16'd7);

    // single inputs and idle
    cyc(10'h000, 0, 10'h1C0, 1);
    expo("only2", 0, 0, 1, 10'h1C0);
    chk("only2.o2", 16'(bus.out2), 16'h1C0);
    cyc(10'h000, 0, 10'h000, 0);
    expo("idle", 0, 0, 0, 0);
    chk("idle.hold", 16'(bus.out2), 16'h1C0);
    cyc(10'h080, 1, 10'h000, 0);
    expo("only1", 1, 10'h080, 0, 0);
    expd("single.defl", 16'd7);

    // reset mid-stream discards in-flight flits
    rst = 1'b1;
    cyc(10'h080, 1, 10'h1C0, 1);
    expo("rst3", 0, 0, 0, 0);
    chk("rst3.o1", 16'(bus.out1), 16'h0);
    rst = 1'b0;
    cyc(10'h080, 1, 10'h081, 1);
    expo("rst3.rr", 1, 10'h080, 1, 10'h081);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
